// File: rtl/trace_pkg.sv
// Shared types, constants and state encoding for the trace_scheduler slice.
package trace_pkg;

   typedef logic [31:0] fixed_real;   // 16.16 unsigned fixed point
   typedef logic [23:0] color;        // 8-bit R, G, B

   typedef struct packed {
      fixed_real x;
      fixed_real y;
      fixed_real z;
   } vector;

   localparam fixed_real T_FAR = 32'h0100_0000;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      TEST,
      WRITE,
      ADVANCE,
      DONE
   } trace_state_t;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trace_scheduler_if.sv
// Pixel-sequencer bundle: frame control, sphere mux select, collision unit and frame-buffer handshake.
interface trace_scheduler_if #(
   parameter int NUM_SPHERES = 4
);
   import trace_pkg::*;

   localparam int SPH_W = idx_w(NUM_SPHERES);

   logic             start;
   logic             busy;
   logic             frame_done;
   logic [9:0]       WriteX;
   logic [9:0]       WriteY;
   logic [SPH_W-1:0] sph_idx;
   color             sph_col;
   fixed_real        cd_tbest;
   fixed_real        cd_tnew;
   logic             cd_collide;
   logic             fb_write;
   color             fb_color;
   logic             fb_ack;

   modport master (
      input  start, sph_col, cd_tnew, cd_collide, fb_ack,
      output busy, frame_done, WriteX, WriteY, sph_idx, cd_tbest, fb_write, fb_color
   );

   modport slave (
      output start, sph_col, cd_tnew, cd_collide, fb_ack,
      input  busy, frame_done, WriteX, WriteY, sph_idx, cd_tbest, fb_write, fb_color
   );

endinterface

// File: rtl/trace_scheduler_depth_shader.sv
// depth_shader: darkens a hit color by the integer part of its distance, saturated at 3.
// Only present when TRACE_DEPTH_SHADE_EN is defined.
`ifdef TRACE_DEPTH_SHADE_EN
module depth_shader
   import trace_pkg::*;
(
   input  color        col_i,
   input  logic [15:0] tint_i,
   output color        col_o
);

   function automatic logic [1:0] sat_shift(input logic [15:0] t);
      return (t > 16'd3) ? 2'd3 : t[1:0];
   endfunction

   logic [1:0] shift;

   assign shift = sat_shift(tint_i);
   assign col_o = {col_i[23:16] >> shift, col_i[15:8] >> shift, col_i[7:0] >> shift};

endmodule
`endif

// File: rtl/trace_scheduler.sv
// trace_scheduler: scans every pixel, tests the look ray against each sphere and writes the nearest color.
// Build option TRACE_DEPTH_SHADE_EN enables depth shading of hit colors via depth_shader.
module trace_scheduler
   import trace_pkg::*;
#(
   parameter int        H_RES       = 640,
   parameter int        V_RES       = 480,
   parameter int        NUM_SPHERES = 4,
   parameter int        LUT_LAT     = 2,
   parameter fixed_real T_FAR       = trace_pkg::T_FAR,
   parameter color      BG_COLOR    = 24'h000000
) (
   input logic               Clk,
   input logic               Reset_n,
   trace_scheduler_if.master bus
);

   localparam int                SPH_W     = idx_w(NUM_SPHERES);
   localparam int                WAIT_W    = idx_w(LUT_LAT);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LUT_LAT - 1);
   localparam logic [SPH_W-1:0]  IDX_LAST  = SPH_W'(NUM_SPHERES - 1);
   localparam logic [9:0]        X_LAST    = 10'(H_RES - 1);
   localparam logic [9:0]        Y_LAST    = 10'(V_RES - 1);

   trace_state_t      state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic [SPH_W-1:0]  idx_q, idx_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   fixed_real         tbest_q, tbest_d;
   color              best_col_q, best_col_d;
   color              out_col;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         idx_q      <= '0;
         wait_q     <= '0;
         tbest_q    <= T_FAR;
         best_col_q <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         idx_q      <= idx_d;
         wait_q     <= wait_d;
         tbest_q    <= tbest_d;
         best_col_q <= best_col_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      idx_d      = idx_q;
      wait_d     = wait_q;
      tbest_d    = tbest_q;
      best_col_d = best_col_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SETUP;
               x_d     = '0;
               y_d     = '0;
               wait_d  = WAIT_INIT;
            end
         end
         // Hold here while the angle and ray LUTs settle on the new WriteX/WriteY.
         SETUP: begin
            tbest_d    = T_FAR;
            best_col_d = BG_COLOR;
            idx_d      = '0;
            if (wait_q == '0) begin
               state_d = TEST;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         // Strict compare keeps the lower sphere index on equal distance.
         TEST: begin
            if (bus.cd_collide && (bus.cd_tnew < tbest_q)) begin
               tbest_d    = bus.cd_tnew;
               best_col_d = bus.sph_col;
            end
            if (idx_q == IDX_LAST) begin
               state_d = WRITE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         WRITE: begin
            if (bus.fb_ack) begin
               state_d = ADVANCE;
            end
         end
         ADVANCE: begin
            wait_d  = WAIT_INIT;
            state_d = SETUP;
            if (x_q == X_LAST) begin
               if (y_q == Y_LAST) begin
                  state_d = DONE;
               end else begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A hit always leaves tbest below T_FAR, so the comparison doubles as the hit flag.
`ifdef TRACE_DEPTH_SHADE_EN
   color shaded_col;

   depth_shader u_depth_shader (
      .col_i  (best_col_q),
      .tint_i (tbest_q[31:16]),
      .col_o  (shaded_col)
   );

   assign out_col = (tbest_q < T_FAR) ? shaded_col : best_col_q;
`else
   assign out_col = best_col_q;
`endif

   assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
   assign bus.frame_done = (state_q == DONE);
   assign bus.fb_write   = (state_q == WRITE);
   assign bus.fb_color   = (state_q == WRITE) ? out_col : '0;
   assign bus.WriteX     = x_q;
   assign bus.WriteY     = y_q;
   assign bus.sph_idx    = idx_q;
   assign bus.cd_tbest   = tbest_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Testbench for trace_scheduler: two instances, a wide frame for pixel-level scenarios and a 4x3 frame sweep.
`timescale 1ns/1ps
module tb_trace_scheduler;
   import trace_pkg::*;

   localparam int   HA = 8;
   localparam int   VA = 6;
   localparam int   HS = 4;
   localparam int   VS = 3;
   localparam int   NS = 4;
   localparam color BG = 24'h0A0B0C;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b1;
   int   errors  = 0;
   int   checks  = 0;
   int   px      = 0;

   always #5 Clk = ~Clk;

   logic      hit_t [NS];
   fixed_real tn_t  [NS];
   color      col_t [NS];

   trace_scheduler_if #(.NUM_SPHERES(NS)) ifa ();
   trace_scheduler_if #(.NUM_SPHERES(NS)) ifs ();

   trace_scheduler #(
      .H_RES(HA), .V_RES(VA), .NUM_SPHERES(NS), .LUT_LAT(2),
      .T_FAR(32'h0100_0000), .BG_COLOR(BG)
   ) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.master)
   );

   trace_scheduler #(
      .H_RES(HS), .V_RES(VS), .NUM_SPHERES(NS), .LUT_LAT(2),
      .T_FAR(32'h0100_0000), .BG_COLOR(BG)
   ) dut_s (
      .Clk(Clk), .Reset_n(Reset_n), .bus(ifs.master)
   );

   // Sphere responder: collision result and color follow sph_idx combinationally.
   assign ifa.sph_col    = col_t[ifa.sph_idx];
   assign ifa.cd_tnew    = tn_t[ifa.sph_idx];
   assign ifa.cd_collide = hit_t[ifa.sph_idx];
   assign ifs.sph_col    = col_t[ifs.sph_idx];
   assign ifs.cd_tnew    = tn_t[ifs.sph_idx];
   assign ifs.cd_collide = hit_t[ifs.sph_idx];

   // Reference: nearest colliding sphere, first one wins a tie, optional depth shading.
   function automatic void model(output color c, output fixed_real t);
      t = 32'h0100_0000;
      c = BG;
      for (int i = 0; i < NS; i++) begin
         if (hit_t[i] && tn_t[i] < t) begin
            t = tn_t[i];
            c = col_t[i];
         end
      end
`ifdef TRACE_DEPTH_SHADE_EN
      if (t < 32'h0100_0000) begin
         int s;
         s = (t[31:16] > 16'd3) ? 3 : int'(t[31:16]);
         c = {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
      end
`endif
   endfunction

   task automatic set_all_miss();
      for (int i = 0; i < NS; i++) begin
         hit_t[i] = 1'b0;
         tn_t[i]  = 32'h0000_1000;
         col_t[i] = 24'hEE_EE_EE;
      end
   endtask

   task automatic wait_write_a(output bit to, output int n);
      to = 1'b1;
      n  = 0;
      repeat (60) begin
         @(negedge Clk);
         n++;
         if (ifa.fb_write) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit to;
      Reset_n = 1'b0;
      ifa.start = 1'b0; ifs.start = 1'b0;
      ifa.fb_ack = 1'b1; ifs.fb_ack = 1'b1;
      set_all_miss();
      repeat (2) @(negedge Clk);
      checks++;
      if (ifa.busy !== 1'b0 || ifa.fb_write !== 1'b0 || ifa.frame_done !== 1'b0 ||
          ifa.WriteX !== 10'd0 || ifa.WriteY !== 10'd0 || ifa.sph_idx !== 2'd0 || ifa.fb_color !== 24'h0)
         begin errors++; $display("FAIL reset_outputs: busy=%b wr=%b done=%b x=%0d y=%0d idx=%0d col=%h, required all zero",
            ifa.busy, ifa.fb_write, ifa.frame_done, ifa.WriteX, ifa.WriteY, ifa.sph_idx, ifa.fb_color); end
      checks++;
      if (ifa.cd_tbest !== 32'h0100_0000)
         begin errors++; $display("FAIL reset_tbest: got %h expected 01000000", ifa.cd_tbest); end
      Reset_n = 1'b1;
      @(negedge Clk);
      ifa.start = 1'b1;
      @(negedge Clk);
      ifa.start = 1'b0;
      to = 1'b1;
      repeat (400) begin
         @(negedge Clk);
         if (ifa.WriteX == 10'd5 && ifa.WriteY == 10'd3) begin to = 1'b0; break; end
      end
      checks++;
      if (to) begin errors++; $display("FAIL reach_pixel_5_3: timeout, pixel not reached"); end
      repeat (3) @(negedge Clk);
      checks++;
      if (ifa.sph_idx !== 2'd1 || ifa.busy !== 1'b1)
         begin errors++; $display("FAIL mid_test_position: idx=%0d busy=%b expected idx=1 busy=1", ifa.sph_idx, ifa.busy); end
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if (ifa.busy !== 1'b0 || ifa.fb_write !== 1'b0 || ifa.frame_done !== 1'b0 ||
          ifa.WriteX !== 10'd0 || ifa.WriteY !== 10'd0 || ifa.sph_idx !== 2'd0 ||
          ifa.fb_color !== 24'h0 || ifa.cd_tbest !== 32'h0100_0000)
         begin errors++; $display("FAIL async_reset: busy=%b wr=%b x=%0d y=%0d idx=%0d col=%h tbest=%h, required idle zeros",
            ifa.busy, ifa.fb_write, ifa.WriteX, ifa.WriteY, ifa.sph_idx, ifa.fb_color, ifa.cd_tbest); end
      repeat (2) begin
         @(negedge Clk);
         checks++;
         if (ifa.fb_write !== 1'b0 || ifa.busy !== 1'b0)
            begin errors++; $display("FAIL reset_held: wr=%b busy=%b expected 0 0", ifa.fb_write, ifa.busy); end
      end
      Reset_n = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         checks++;
         if (ifa.busy !== 1'b0 || ifa.fb_write !== 1'b0 || ifa.WriteX !== 10'd0)
            begin errors++; $display("FAIL post_reset_idle: busy=%b wr=%b x=%0d expected 0 0 0", ifa.busy, ifa.fb_write, ifa.WriteX); end
      end
   endtask

   task automatic test_nearest();
      bit to; int n; color ec; fixed_real et;
      set_all_miss();
      hit_t[1] = 1'b1; tn_t[1] = 32'h0003_0000; col_t[1] = 24'h11_22_33;
      hit_t[2] = 1'b1; tn_t[2] = 32'h0001_8000; col_t[2] = 24'h44_55_66;
      hit_t[3] = 1'b1; tn_t[3] = 32'h0001_8000; col_t[3] = 24'h77_88_99;
      model(ec, et);
      ifa.start = 1'b1;
      @(negedge Clk);
      ifa.start = 1'b0;
      px = 0;
      wait_write_a(to, n);
      checks++;
      if (to || n != 6) begin errors++; $display("FAIL first_write_latency: timeout=%b cycles=%0d expected 7 after start", to, n + 1); end
      checks++;
      if (ifa.fb_color !== ec) begin errors++; $display("FAIL nearest_color: got %h expected %h", ifa.fb_color, ec); end
`ifndef TRACE_DEPTH_SHADE_EN
      checks++;
      if (ifa.fb_color !== 24'h44_55_66) begin errors++; $display("FAIL nearest_tie_sph2: got %h expected 445566", ifa.fb_color); end
`endif
      checks++;
      if (ifa.cd_tbest !== 32'h0001_8000 || ifa.WriteX !== 10'd0 || ifa.WriteY !== 10'd0)
         begin errors++; $display("FAIL nearest_tbest_xy: tbest=%h x=%0d y=%0d expected 00018000 0 0", ifa.cd_tbest, ifa.WriteX, ifa.WriteY); end
   endtask

   task automatic test_miss();
      bit to; int n;
      set_all_miss();
      hit_t[3] = 1'b1; tn_t[3] = 32'h0100_0000; col_t[3] = 24'h12_34_56;
      px = 1;
      wait_write_a(to, n);
      checks++;
      if (to || ifa.fb_color !== BG)
         begin errors++; $display("FAIL miss_color: timeout=%b got %h expected %h", to, ifa.fb_color, BG); end
      checks++;
      if (ifa.cd_tbest !== 32'h0100_0000 || ifa.WriteX !== 10'd1)
         begin errors++; $display("FAIL miss_tbest: tbest=%h x=%0d expected 01000000 1", ifa.cd_tbest, ifa.WriteX); end
   endtask

   task automatic test_stall();
      bit to; int n; color ec; fixed_real et; logic [9:0] x0, y0; color c0;
      @(negedge Clk);
      ifa.fb_ack = 1'b0;
      set_all_miss();
      hit_t[0] = 1'b1; tn_t[0] = 32'h0000_8000; col_t[0] = 24'hAA_BB_CC;
      model(ec, et);
      px = 2;
      wait_write_a(to, n);
      x0 = ifa.WriteX; y0 = ifa.WriteY; c0 = ifa.fb_color;
      checks++;
      if (to || x0 !== 10'd2 || y0 !== 10'd0 || c0 !== ec)
         begin errors++; $display("FAIL stall_first: timeout=%b x=%0d y=%0d col=%h expected 2 0 %h", to, x0, y0, c0, ec); end
      repeat (5) begin
         @(negedge Clk);
         checks++;
         if (ifa.fb_write !== 1'b1 || ifa.WriteX !== x0 || ifa.WriteY !== y0 || ifa.fb_color !== c0)
            begin errors++; $display("FAIL stall_hold: wr=%b x=%0d y=%0d col=%h expected 1 %0d %0d %h",
               ifa.fb_write, ifa.WriteX, ifa.WriteY, ifa.fb_color, x0, y0, c0); end
      end
      ifa.fb_ack = 1'b1;
      @(negedge Clk);
      checks++;
      if (ifa.fb_write !== 1'b0 || ifa.WriteX !== 10'd2)
         begin errors++; $display("FAIL stall_release: wr=%b x=%0d expected 0 2", ifa.fb_write, ifa.WriteX); end
      @(negedge Clk);
      checks++;
      if (ifa.WriteX !== 10'd3) begin errors++; $display("FAIL stall_advance: x=%0d expected 3", ifa.WriteX); end
      px = 3;
   endtask

`ifdef TRACE_DEPTH_SHADE_EN
   task automatic test_shading();
      bit to; int n;
      set_all_miss();
      hit_t[0] = 1'b1; tn_t[0] = 32'h0002_0000; col_t[0] = 24'hFF_80_40;
      wait_write_a(to, n);
      checks++;
      if (to || ifa.fb_color !== 24'h3F_20_10)
         begin errors++; $display("FAIL shade_2: timeout=%b got %h expected 3F2010", to, ifa.fb_color); end
      tn_t[0] = 32'h0005_0000;
      @(negedge Clk);
      wait_write_a(to, n);
      checks++;
      if (to || ifa.fb_color !== 24'h1F_10_08)
         begin errors++; $display("FAIL shade_sat3: timeout=%b got %h expected 1F1008", to, ifa.fb_color); end
      @(negedge Clk);
      px = px + 2;
   endtask
`endif

   task automatic test_random();
      bit to; int n; int stall; color ec; fixed_real et;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < NS; i++) begin
            hit_t[i] = 1'($urandom_range(0, 1));
            col_t[i] = 24'($urandom());
            case ($urandom_range(0, 3))
               0:       tn_t[i] = 32'h0001_8000;
               1:       tn_t[i] = {16'($urandom_range(0, 5)), 16'h0000};
               2:       tn_t[i] = $urandom();
               default: tn_t[i] = 32'h0100_0000;
            endcase
         end
         model(ec, et);
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         ifa.fb_ack = (stall == 0);
         wait_write_a(to, n);
         checks++;
         if (to || ifa.fb_color !== ec || ifa.cd_tbest !== et ||
             ifa.WriteX !== 10'(px % HA) || ifa.WriteY !== 10'(px / HA))
            begin errors++; $display("FAIL random_pixel%0d: timeout=%b col=%h tbest=%h x=%0d y=%0d expected %h %h %0d %0d",
               px, to, ifa.fb_color, ifa.cd_tbest, ifa.WriteX, ifa.WriteY, ec, et, px % HA, px / HA); end
         repeat (stall) begin
            @(negedge Clk);
            checks++;
            if (ifa.fb_write !== 1'b1 || ifa.fb_color !== ec)
               begin errors++; $display("FAIL random_stall: wr=%b col=%h expected 1 %h", ifa.fb_write, ifa.fb_color, ec); end
         end
         ifa.fb_ack = 1'b1;
         @(negedge Clk);
         px++;
      end
   endtask

   task automatic test_frame_sweep();
      int nwr = 0;
      int ndone = 0;
      set_all_miss();
      ifs.fb_ack = 1'b1;
      ifs.start = 1'b1;
      @(negedge Clk);
      ifs.start = 1'b0;
      for (int c = 1; c <= 115; c++) begin
         if (c == 1) begin
            checks++;
            if (ifs.busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_start: got %b expected 1", ifs.busy); end
         end
         if (ifs.fb_write) begin
            checks++;
            if (c != 7 + 8 * nwr || ifs.WriteX !== 10'(nwr % HS) || ifs.WriteY !== 10'(nwr / HS) ||
                ifs.fb_color !== BG || ifs.cd_tbest !== 32'h0100_0000)
               begin errors++; $display("FAIL sweep_write%0d: cycle=%0d x=%0d y=%0d col=%h expected cycle=%0d x=%0d y=%0d col=%h",
                  nwr, c, ifs.WriteX, ifs.WriteY, ifs.fb_color, 7 + 8 * nwr, nwr % HS, nwr / HS, BG); end
            nwr++;
         end
         if (ifs.frame_done) begin
            ndone++;
            checks++;
            if (c != 97 || ifs.busy !== 1'b0)
               begin errors++; $display("FAIL sweep_done_cycle: cycle=%0d busy=%b expected 97 0", c, ifs.busy); end
         end
         ifs.start = (c >= 20 && c <= 22) || (c == 97);
         @(negedge Clk);
      end
      ifs.start = 1'b0;
      checks++;
      if (nwr != HS * VS) begin errors++; $display("FAIL sweep_write_count: got %0d expected %0d", nwr, HS * VS); end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL sweep_done_pulses: got %0d expected 1", ndone); end
      checks++;
      if (ifs.busy !== 1'b0 || ifs.WriteX !== 10'(HS - 1) || ifs.WriteY !== 10'(VS - 1))
         begin errors++; $display("FAIL sweep_final: busy=%b x=%0d y=%0d expected 0 %0d %0d",
            ifs.busy, ifs.WriteX, ifs.WriteY, HS - 1, VS - 1); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nearest();
      test_miss();
      test_stall();
`ifdef TRACE_DEPTH_SHADE_EN
      test_shading();
`endif
      test_random();
      test_frame_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
